// File: rtl/commit_ctrl_pkg.sv
// Shared definitions for the commit stage: ROB tag sizing, head_type codes
// and the commit FSM state encodings.
package commit_ctrl_pkg;

    localparam int ROB_SZ_LOG_DEF = 3;
    localparam int ROB_TAG_W      = ROB_SZ_LOG_DEF + 1;

    localparam logic [1:0] COMMIT_ALU  = 2'd0;
    localparam logic [1:0] COMMIT_ST   = 2'd1;
    localparam logic [1:0] COMMIT_BR   = 2'd2;
    localparam logic [1:0] COMMIT_HALT = 2'd3;

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_ST_WAIT = 2'd1;
    localparam logic [1:0] S_FLUSH   = 2'd2;
    localparam logic [1:0] S_HALT    = 2'd3;

    function automatic int tag_width(input int sz_log);
        return sz_log + 1;
    endfunction

endpackage

// File: rtl/commit_ctrl.sv
// In-order retirement from the ROB head: same-cycle register commit,
// serialized store handshake, one-cycle flush on mispredict, sticky halt.
module commit_ctrl
    import commit_ctrl_pkg::*;
#(
    parameter int ROB_SZ_LOG = 3,
    parameter int XLEN       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          rob_empty,
    input  logic                          head_ready,
    input  logic [tag_width(ROB_SZ_LOG)-1:0] head_tag,
    input  logic [1:0]                    head_type,
    input  logic                          head_rd_hv,
    input  logic [4:0]                    head_rd,
    input  logic [XLEN-1:0]               head_value,
    input  logic                          head_mispred,
    input  logic [XLEN-1:0]               head_target,
    input  logic                          st_done,
    output logic                          rob_pop,
    output logic                          reg_upd,
    output logic [4:0]                    reg_rd,
    output logic [XLEN-1:0]               reg_res,
    output logic [tag_width(ROB_SZ_LOG)-1:0] reg_head,
    output logic                          st_req,
    output logic [tag_width(ROB_SZ_LOG)-1:0] st_tag,
    output logic                          flush,
    output logic [XLEN-1:0]               flush_pc,
    output logic                          halted,
    output logic [31:0]                   commit_cnt
);

    logic [1:0] state;
    logic       go;
    logic       st_fin;

    assign go     = (state == S_RUN) && rdy && !rob_empty && head_ready;
    assign st_fin = (state == S_ST_WAIT) && rdy && st_done;

    // Stores pop only when memory acknowledges; everything else pops on go.
    always_comb begin
        rob_pop  = st_fin || (go && (head_type != COMMIT_ST));
        reg_upd  = go && head_rd_hv &&
                   ((head_type == COMMIT_ALU) || (head_type == COMMIT_BR));
        reg_rd   = '0;
        reg_res  = '0;
        reg_head = '0;
        if (reg_upd) begin
            reg_rd   = head_rd;
            reg_res  = head_value;
            reg_head = head_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RUN;
            st_req     <= 1'b0;
            st_tag     <= '0;
            flush      <= 1'b0;
            flush_pc   <= '0;
            halted     <= 1'b0;
            commit_cnt <= '0;
        end else if (rdy) begin
            commit_cnt <= commit_cnt + 32'(rob_pop);
            case (state)
                S_RUN: begin
                    if (go) begin
                        case (head_type)
                            COMMIT_ST: begin
                                st_req <= 1'b1;
                                st_tag <= head_tag;
                                state  <= S_ST_WAIT;
                            end
                            COMMIT_BR: begin
                                if (head_mispred) begin
                                    flush    <= 1'b1;
                                    flush_pc <= head_target;
                                    state    <= S_FLUSH;
                                end
                            end
                            COMMIT_HALT: begin
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end
                            default: ;
                        endcase
                    end
                end
                S_ST_WAIT: begin
                    if (st_done) begin
                        st_req <= 1'b0;
                        state  <= S_RUN;
                    end
                end
                S_FLUSH: begin
                    flush <= 1'b0;
                    state <= S_RUN;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed bench for commit_ctrl with a per-cycle expectation scoreboard.
module tb_commit_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rob_empty;
    logic        head_ready;
    logic [3:0]  head_tag;
    logic [1:0]  head_type;
    logic        head_rd_hv;
    logic [4:0]  head_rd;
    logic [31:0] head_value;
    logic        head_mispred;
    logic [31:0] head_target;
    logic        st_done;
    logic        rob_pop;
    logic        reg_upd;
    logic [4:0]  reg_rd;
    logic [31:0] reg_res;
    logic [3:0]  reg_head;
    logic        st_req;
    logic [3:0]  st_tag;
    logic        flush;
    logic [31:0] flush_pc;
    logic        halted;
    logic [31:0] commit_cnt;

    commit_ctrl #(.ROB_SZ_LOG(3), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rob_empty(rob_empty),
        .head_ready(head_ready), .head_tag(head_tag), .head_type(head_type),
        .head_rd_hv(head_rd_hv), .head_rd(head_rd), .head_value(head_value),
        .head_mispred(head_mispred), .head_target(head_target),
        .st_done(st_done), .rob_pop(rob_pop), .reg_upd(reg_upd),
        .reg_rd(reg_rd), .reg_res(reg_res), .reg_head(reg_head),
        .st_req(st_req), .st_tag(st_tag), .flush(flush), .flush_pc(flush_pc),
        .halted(halted), .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pop;
        logic        upd;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [3:0]  head;
        logic        st_req;
        logic [3:0]  st_tag;
        logic        flush;
        logic [31:0] flush_pc;
        logic        halted;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    int n_pass  = 0;
    int n_total = 0;

    logic        e_st_req;
    logic [3:0]  e_st_tag;
    logic        e_flush;
    logic [31:0] e_flush_pc;
    logic        e_halted;
    logic [31:0] e_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rob_pop",    32'(rob_pop),   32'(e.pop));
            chk("reg_upd",    32'(reg_upd),   32'(e.upd));
            chk("reg_rd",     32'(reg_rd),    32'(e.rd));
            chk("reg_res",    reg_res,        e.res);
            chk("reg_head",   32'(reg_head),  32'(e.head));
            chk("st_req",     32'(st_req),    32'(e.st_req));
            chk("st_tag",     32'(st_tag),    32'(e.st_tag));
            chk("flush",      32'(flush),     32'(e.flush));
            chk("flush_pc",   flush_pc,       e.flush_pc);
            chk("halted",     32'(halted),    32'(e.halted));
            chk("commit_cnt", commit_cnt,     e.cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push this cycle's expected outputs; the running pop count feeds commit_cnt.
    task automatic expect_cyc(input logic pop, input logic upd, input logic [4:0] rd,
                              input logic [31:0] res, input logic [3:0] head);
        exp_t e;
        e.pop = pop; e.upd = upd; e.rd = rd; e.res = res; e.head = head;
        e.st_req = e_st_req; e.st_tag = e_st_tag; e.flush = e_flush;
        e.flush_pc = e_flush_pc; e.halted = e_halted; e.cnt = e_cnt;
        sb.push_back(e);
        if (pop) e_cnt = e_cnt + 32'd1;
    endtask

    task automatic set_head(input logic [1:0] typ, input logic [3:0] tag, input logic hv,
                            input logic [4:0] rd, input logic [31:0] val,
                            input logic mis, input logic [31:0] tgt);
        rob_empty = 1'b0; head_ready = 1'b1;
        head_type = typ; head_tag = tag; head_rd_hv = hv; head_rd = rd;
        head_value = val; head_mispred = mis; head_target = tgt;
    endtask

    task automatic idle_in();
        rob_empty = 1'b1; head_ready = 1'b0; head_type = 2'd0; head_tag = 4'd0;
        head_rd_hv = 1'b0; head_rd = 5'd0; head_value = 32'd0;
        head_mispred = 1'b0; head_target = 32'd0;
    endtask

    task automatic clr_exp();
        e_st_req = 1'b0; e_st_tag = 4'd0; e_flush = 1'b0;
        e_flush_pc = 32'd0; e_halted = 1'b0; e_cnt = 32'd0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; st_done = 1'b0;
        idle_in();
        clr_exp();
        tick(); tick();

        // reset state
        tick(); rst = 1'b0; expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);

        // three back-to-back ALU commits, including rd=0
        tick(); set_head(2'd0, 4'd1, 1, 5'd5, 32'h11, 0, 0); expect_cyc(1, 1, 5'd5, 32'h11, 4'd1);
        tick(); set_head(2'd0, 4'd2, 1, 5'd6, 32'h22, 0, 0); expect_cyc(1, 1, 5'd6, 32'h22, 4'd2);
        tick(); set_head(2'd0, 4'd3, 1, 5'd0, 32'h33, 0, 0); expect_cyc(1, 1, 5'd0, 32'h33, 4'd3);
        tick(); idle_in(); expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);

        // store: st_req high 3 cycles, pop coincident with st_done
        tick(); set_head(2'd1, 4'd4, 0, 5'd0, 32'd0, 0, 0); expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        e_st_req = 1'b1; e_st_tag = 4'd4;
        tick(); expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        tick(); expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        tick(); st_done = 1'b1; expect_cyc(1, 0, 5'd0, 32'd0, 4'd0);

        // mispredicted JAL-type branch with link write
        tick(); st_done = 1'b0; e_st_req = 1'b0;
        set_head(2'd2, 4'd5, 1, 5'd1, 32'h104, 1, 32'h200); expect_cyc(1, 1, 5'd1, 32'h104, 4'd5);
        e_flush = 1'b1; e_flush_pc = 32'h200;
        tick(); set_head(2'd0, 4'd6, 1, 5'd7, 32'h77, 0, 0); expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        e_flush = 1'b0;
        tick(); expect_cyc(1, 1, 5'd7, 32'h77, 4'd6);
        // correctly predicted branch without a link write: no flush follows
        tick(); set_head(2'd2, 4'd7, 0, 5'd3, 32'h55, 0, 32'h300); expect_cyc(1, 0, 5'd0, 32'd0, 4'd0);

        // store stalled by rdy=0; st_done during the stall is ignored
        tick(); set_head(2'd1, 4'd8, 0, 5'd0, 32'd0, 0, 0); expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        e_st_req = 1'b1; e_st_tag = 4'd8;
        tick(); rdy = 1'b0; expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        tick(); st_done = 1'b1; expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        tick(); st_done = 1'b0; expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        tick(); expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        tick(); rdy = 1'b1; expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        tick(); st_done = 1'b1; expect_cyc(1, 0, 5'd0, 32'd0, 4'd0);

        // no retirement without a ready head or with rdy low
        tick(); st_done = 1'b0; e_st_req = 1'b0; idle_in(); expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        tick(); set_head(2'd0, 4'd9, 1, 5'd9, 32'h99, 0, 0); head_ready = 1'b0; expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        tick(); rob_empty = 1'b1; head_ready = 1'b1; expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        tick(); rob_empty = 1'b0; rdy = 1'b0; expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        tick(); rdy = 1'b1; head_ready = 1'b0; expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);

        // HALT is absorbing
        tick(); set_head(2'd3, 4'd9, 0, 5'd0, 32'd0, 0, 0); expect_cyc(1, 0, 5'd0, 32'd0, 4'd0);
        e_halted = 1'b1;
        tick(); set_head(2'd0, 4'd10, 1, 5'd2, 32'hAA, 0, 0); expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        tick(); expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);

        // reset out of HALT, then reset aborting ST_WAIT
        tick(); rst = 1'b1; expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        tick(); rst = 1'b0; clr_exp();
        set_head(2'd1, 4'd10, 0, 5'd0, 32'd0, 0, 0); expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        e_st_req = 1'b1; e_st_tag = 4'd10;
        tick(); expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        tick(); rst = 1'b1; expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        tick(); rst = 1'b0; clr_exp(); expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);
        // back in RUN: the same store head is accepted again
        e_st_req = 1'b1; e_st_tag = 4'd10;
        tick(); st_done = 1'b1; expect_cyc(1, 0, 5'd0, 32'd0, 4'd0);
        tick(); st_done = 1'b0; e_st_req = 1'b0; idle_in(); expect_cyc(0, 0, 5'd0, 32'd0, 4'd0);

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/commit_ctrl.md
Name: commit_ctrl

Overview:
- Sequences in-order retirement from the reorder buffer head into the renamed register file, the store path, and the front end.
- Each cycle it decides whether the head entry retires. On retire it drives the register-file update strobe (commit rd, value, head tag) and pops the ROB.
- Stores are serialized through a memory handshake.
- A branch mispredict produces a one-cycle flush broadcast and a redirect PC.
- Sits between the ROB, the register file, the load/store buffer and the fetch unit.

Parameters:
ROB_SZ_LOG, 3, ROB tag width is ROB_SZ_LOG+1 bits. Tag 0 is reserved as "no producer".
XLEN, 32, data and PC width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low freezes the block
rob_empty  in  1  ROB holds no entries
head_ready  in  1  head entry result valid
head_tag  in  ROB_SZ_LOG+1  ROB index of head
head_type  in  2  0=ALU/LOAD, 1=STORE, 2=BRANCH/JUMP, 3=HALT
head_rd_hv  in  1  head writes a destination register
head_rd  in  5  destination register
head_value  in  XLEN  result value
head_mispred  in  1  branch outcome differs from prediction
head_target  in  XLEN  correct next PC for mispredicted branch
st_done  in  1  memory finished the requested store (pulse)
rob_pop  out  1  retire head this cycle (combinational)
reg_upd  out  1  register-file commit strobe (combinational)
reg_rd  out  5  commit rd
reg_res  out  XLEN  commit value
reg_head  out  ROB_SZ_LOG+1  commit head tag
st_req  out  1  store request, registered, level
st_tag  out  ROB_SZ_LOG+1  tag of store in flight, registered
flush  out  1  pipeline flush pulse, registered
flush_pc  out  XLEN  redirect PC, registered
halted  out  1  HALT retired, registered, sticky
commit_cnt  out  32  retired-instruction count, registered, wraps

Behaviour:
- State register: RUN, ST_WAIT, FLUSH, HALT.
- Reset values: state=RUN; st_req=0, st_tag=0, flush=0, flush_pc=0, halted=0, commit_cnt=0.
- Reset is synchronous and wins over rdy and all other events; it aborts ST_WAIT without completing the store.
- rdy=0 freezes everything:
  - rob_pop=0, reg_upd=0.
  - State and registered outputs hold; st_req stays asserted if already asserted.
  - An st_done arriving while rdy=0 is ignored.
- Define go = state==RUN && rdy && !rob_empty && head_ready.
- RUN, go, type 0:
  - rob_pop=1; reg_upd=head_rd_hv; reg_rd/reg_res/reg_head = head_rd/head_value/head_tag.
  - Same-cycle combinational commit, so back-to-back retirement at one per cycle.
  - rd=0 is still strobed; the register file discards the data.
- RUN, go, type 1:
  - No pop this cycle.
  - Next edge: st_req<=1, st_tag<=head_tag, state<=ST_WAIT.
- ST_WAIT:
  - st_req held high.
  - On rdy && st_done: rob_pop=1 that cycle (reg_upd=0); st_req<=0 and state<=RUN at the edge.
  - Minimum store retire latency is 2 cycles.
- RUN, go, type 2:
  - rob_pop=1; reg_upd=head_rd_hv (JAL/JALR link value).
  - If head_mispred: flush<=1, flush_pc<=head_target, state<=FLUSH.
- FLUSH:
  - flush is high for exactly this one cycle; no retirement.
  - Next edge: flush<=0, state<=RUN.
  - flush_pc holds its last value.
  - Commit-to-flush latency is 1 cycle; the first new commit is possible 2 cycles after the mispredict pop.
- RUN, go, type 3:
  - rob_pop=1; halted<=1, state<=HALT.
  - HALT is absorbing until rst.
- commit_cnt increments by 1 on every cycle with rob_pop=1; wraps 0xFFFFFFFF->0.
- reg_rd/reg_res/reg_head drive 0 whenever reg_upd=0.
- Retirement is gated entirely by go: a head that is not ready, or an empty ROB, yields no pop and no strobe.

Decomposition:
- Shared package/def header: ROB tag width macro (shared with the register file and ROB), the head_type encodings (COMMIT_ALU, COMMIT_ST, COMMIT_BR, COMMIT_HALT), and the state encodings.
- No sub-module; a single FSM plus combinational commit decode. The optional counter may live inline.

Test Plan:
- Reset, then three ready ALU heads (rd=5,6,0, values 0x11,0x22,0x33, tags 1,2,3) -> reg_upd and rob_pop high for 3 consecutive cycles with matching rd/value/tag; commit_cnt=3.
- Store at tag 4; st_done asserted 3 cycles after st_req rises -> st_tag=4; st_req high 3 cycles; rob_pop for exactly one cycle coincident with st_done; reg_upd never high.
- Mispredicted branch, rd_hv=1, rd=1, value 0x104, target 0x200 -> same-cycle reg_upd for x1=0x104 and pop; next cycle flush=1, flush_pc=0x200; following cycle flush=0 and a ready head is accepted.
- rdy held low for 4 cycles during ST_WAIT, with st_done pulsed while rdy=0 -> no pop; st_req stays high; the store retires only on a later st_done with rdy=1.
- head_ready=0 or rob_empty=1 for 5 cycles -> no pop, no strobe, commit_cnt unchanged; HALT head -> halted=1 and no further pops despite ready heads; rst mid-ST_WAIT -> st_req=0, state RUN next cycle.
